// File: rtl/key_capture_defs.sv
// Shared constants and types for the key_capture chord-entry block.
package key_capture_defs;

  localparam int unsigned CNT_W          = 20;
  localparam int unsigned DEF_DB_CYCLES  = 50000;
  localparam int unsigned DEF_WIN_CYCLES = 250000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Terminal count for a cycle-length parameter; a length of 0 acts as 1.
  function automatic logic [CNT_W-1:0] cnt_limit(input int unsigned cycles);
    int unsigned c;
    c = (cycles == 0) ? 1 : cycles;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key lane: 2-flop synchroniser followed by a hold-time debouncer.
module key_debounce
  import key_capture_defs::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic C,
  input  logic clr_n,
  input  logic raw,
  output logic lvl
);

  localparam logic [CNT_W-1:0] LIM = cnt_limit(DB_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_lvl;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge C or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == LIM) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign lvl = r_lvl;

endmodule

// File: rtl/key_capture.sv
// Four-lane chord capture: debounced presses are OR-collected over a window
// starting at the first press, then presented once on D with a load strobe.
module key_capture
  import key_capture_defs::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned WIN_CYCLES = DEF_WIN_CYCLES
) (
  input  logic       C,
  input  logic       clr_n,
  input  logic [3:0] key_raw,
  output logic [3:0] key_lvl,
  output logic [3:0] D,
  output logic       load,
  output logic       busy
);

  localparam logic [CNT_W-1:0] WLIM = cnt_limit(WIN_CYCLES);

  logic [3:0]       w_lvl;
  logic [3:0]       w_press;
  logic [3:0]       r_lvl_d;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_acc;
  logic [3:0]       w_acc_nxt;
  logic [CNT_W-1:0] r_win;
  logic [CNT_W-1:0] w_win_nxt;
  logic [3:0]       r_d;
  logic             r_load;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .C     (C),
      .clr_n (clr_n),
      .raw   (key_raw[g]),
      .lvl   (w_lvl[g])
    );
  end

  assign w_press = w_lvl & ~r_lvl_d;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_win_nxt   = r_win;
    case (r_state)
      IDLE: begin
        if (|w_press) begin
          w_state_nxt = COLLECT;
          w_acc_nxt   = w_press;
          w_win_nxt   = '0;
        end
      end
      COLLECT: begin
        w_acc_nxt = r_acc | w_press;
        if (r_win == WLIM) begin
          w_state_nxt = EMIT;
        end else begin
          w_win_nxt = r_win + CNT_W'(1);
        end
      end
      EMIT: w_state_nxt = HOLD;
      HOLD: begin
        if (w_lvl == 4'b0000) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // D/load are registered on entry to EMIT so they are valid during the EMIT
  // cycle itself, which includes any press seen in the last COLLECT cycle.
  always_ff @(posedge C or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_win   <= '0;
      r_lvl_d <= '0;
      r_d     <= '0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_win   <= w_win_nxt;
      r_lvl_d <= w_lvl;
      r_load  <= (w_state_nxt == EMIT);
      if (w_state_nxt == EMIT) begin
        r_d <= w_acc_nxt;
      end
    end
  end

  assign key_lvl = w_lvl;
  assign D       = r_d;
  assign load    = r_load;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_key_capture.sv
// Directed bench for key_capture with DB_CYCLES=4, WIN_CYCLES=8.
module tb_key_capture;

  logic       C;
  logic       clr_n;
  logic [3:0] key_raw;
  logic [3:0] key_lvl;
  logic [3:0] D;
  logic       load;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int load_cnt = 0;
  int load_cyc = -1;
  logic [3:0] last_d = '0;
  logic prev_load = 1'b0;
  int viol = 0;

  key_capture #(.DB_CYCLES(4), .WIN_CYCLES(8)) dut (
    .C       (C),
    .clr_n   (clr_n),
    .key_raw (key_raw),
    .key_lvl (key_lvl),
    .D       (D),
    .load    (load),
    .busy    (busy)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  always @(posedge C) cyc <= cyc + 1;

  // Record every load strobe; flag back-to-back strobes or an empty chord.
  always @(negedge C) begin
    if (clr_n) begin
      if (load) begin
        load_cnt++;
        last_d   = D;
        load_cyc = cyc;
        if (prev_load || D == 4'b0000) viol++;
      end
      prev_load = load;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int base;
    int bad;

    clr_n   = 1'b0;
    key_raw = 4'b0000;
    #3;
    chk("rst_D", 32'(D), 32'h0);
    chk("rst_load", 32'(load), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_lvl", 32'(key_lvl), 32'h0);
    step(2);
    clr_n = 1'b1;
    step(2);

    // Single press on lane1
    c0 = cyc;
    key_raw = 4'b0010;
    step(5);
    chk("db_pre", 32'(key_lvl), 32'h0);
    step(1);
    chk("db_post", 32'(key_lvl), 32'h2);
    step(10);
    chk("single_cnt", 32'(load_cnt), 32'd1);
    chk("single_lat", 32'(load_cyc), 32'(c0 + 15));
    chk("single_D", 32'(last_d), 32'h2);
    chk("single_busy", 32'(busy), 32'h1);
    key_raw = 4'b0000;
    step(10);
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_once", 32'(load_cnt), 32'd1);

    // Chord spread: lane0 then lane3 five cycles later
    c0 = cyc;
    key_raw = 4'b0001;
    step(5);
    key_raw = 4'b1001;
    step(11);
    chk("spread_cnt", 32'(load_cnt), 32'd2);
    chk("spread_lat", 32'(load_cyc), 32'(c0 + 15));
    chk("spread_D", 32'(last_d), 32'h9);
    key_raw = 4'b0000;
    step(10);

    // Bounce on lane1: 2 cycles high, 2 cycles low
    base = load_cnt;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      key_raw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) begin
        step(1);
        if (key_lvl[1]) bad++;
      end
    end
    key_raw = 4'b0000;
    step(20);
    chk("bounce_lvl_hi", 32'(bad), 32'd0);
    chk("bounce_lvl", 32'(key_lvl), 32'h0);
    chk("bounce_noload", 32'(load_cnt), 32'(base));
    chk("bounce_busy", 32'(busy), 32'h0);

    // Hold-off: extra press while chord still held is ignored
    base = load_cnt;
    key_raw = 4'b0110;
    step(16);
    chk("hold_cnt", 32'(load_cnt), 32'(base + 1));
    chk("hold_D", 32'(last_d), 32'h6);
    key_raw = 4'b0111;
    step(20);
    chk("hold_lvl", 32'(key_lvl), 32'h7);
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_ignored", 32'(load_cnt), 32'(base + 1));
    key_raw = 4'b0000;
    step(10);
    chk("hold_exit", 32'(busy), 32'h0);
    c0 = cyc;
    key_raw = 4'b0001;
    step(16);
    chk("hold_next_D", 32'(last_d), 32'h1);
    chk("hold_next_lat", 32'(load_cyc), 32'(c0 + 15));
    key_raw = 4'b0000;
    step(10);

    // Reset inside the collection window discards the chord
    base = load_cnt;
    key_raw = 4'b0100;
    step(10);
    chk("rcol_busy", 32'(busy), 32'h1);
    clr_n   = 1'b0;
    key_raw = 4'b0000;
    #1;
    chk("rcol_D", 32'(D), 32'h0);
    chk("rcol_busy0", 32'(busy), 32'h0);
    chk("rcol_lvl", 32'(key_lvl), 32'h0);
    chk("rcol_load", 32'(load), 32'h0);
    step(2);
    clr_n = 1'b1;
    step(30);
    chk("rcol_noload", 32'(load_cnt), 32'(base));
    chk("rcol_D_after", 32'(D), 32'h0);
    chk("rcol_idle", 32'(busy), 32'h0);

    // Key held through reset debounces afresh after release
    clr_n   = 1'b0;
    key_raw = 4'b1000;
    step(2);
    clr_n = 1'b1;
    c0 = cyc;
    step(5);
    chk("rheld_pre", 32'(key_lvl), 32'h0);
    step(1);
    chk("rheld_post", 32'(key_lvl), 32'h8);
    step(10);
    chk("rheld_D", 32'(last_d), 32'h8);
    chk("rheld_lat", 32'(load_cyc), 32'(c0 + 15));
    key_raw = 4'b0000;
    step(10);

    // Boundary: lane2 press pulse lands on the last COLLECT cycle
    c0 = cyc;
    key_raw = 4'b0001;
    step(8);
    key_raw = 4'b0101;
    step(8);
    chk("edge_in_D", 32'(last_d), 32'h5);
    chk("edge_in_lat", 32'(load_cyc), 32'(c0 + 15));
    key_raw = 4'b0000;
    step(10);

    // One cycle later the press falls into EMIT and is dropped
    base = load_cnt;
    key_raw = 4'b0001;
    step(9);
    key_raw = 4'b0101;
    step(7);
    chk("edge_out_D", 32'(last_d), 32'h1);
    step(10);
    chk("edge_out_cnt", 32'(load_cnt), 32'(base + 1));
    key_raw = 4'b0000;
    step(12);
    chk("edge_out_idle", 32'(busy), 32'h0);

    chk("load_rules", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
